// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing helpers for the fifo_reader drain engine.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } rd_state_e;

    localparam int unsigned DW_DEFAULT = 8;

    // Width of the shared strobe/gap down-counter; it must hold max(rd_low, gap) - 1.
    function automatic int unsigned cyc_cnt_w(input int unsigned rd_low, input int unsigned gap);
        int unsigned mx;
        mx = (rd_low > gap) ? rd_low : gap;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Two-entry valid/ready output buffer; head entry drives the stream, occ_o reports fill level.
module fifo_rd_buf
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic [1:0]    occ_o
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    occ_q, occ_d;
    logic          pop;

    always_comb begin
        pop    = (occ_q != 2'd0) && ready_i;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({wr_en_i, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = wr_data_i;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    tail_d = wr_data_i;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous write and pop: occupancy unchanged, the new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = wr_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = wr_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = (occ_q != 2'd0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Autonomous FIFO drain engine: timed active-low read strobes, capture at strobe end, valid/ready output.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DW            = DW_DEFAULT,
    parameter int unsigned RD_LOW_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             nempty,
    input  logic [DW-1:0]    fifo_data,
    output logic             fiford,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count
);

    localparam int unsigned   CW       = cyc_cnt_w(RD_LOW_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] RD_LOAD  = CW'(RD_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    rd_state_e        state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic             capture;
    logic [1:0]       occ;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        rd_count_d = rd_count_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                // Occupancy is checked before launch so the eventual capture always has room.
                if (en && nempty && (occ < 2'd2)) begin
                    state_d = STROBE;
                    cyc_d   = RD_LOAD;
                end
            end
            STROBE: begin
                if (cyc_q == '0) begin
                    capture    = 1'b1;
                    rd_count_d = rd_count_q + CNT_W'(1);
                    state_d    = GAP;
                    cyc_d      = GAP_LOAD;
                end else begin
                    cyc_d = cyc_q - CW'(1);
                end
            end
            GAP: begin
                if (cyc_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            rd_count_q <= rd_count_d;
        end
    end

    fifo_rd_buf #(
        .DW(DW)
    ) u_buf (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (capture),
        .wr_data_i (fifo_data),
        .ready_i   (dout_ready),
        .data_o    (dout),
        .valid_o   (dout_valid),
        .occ_o     (occ)
    );

    // Decoded straight from the state register so reset forces the strobe high without a clock.
    assign fiford   = (state_q != STROBE);
    assign busy     = (state_q != IDLE);
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized and directed bench for fifo_reader against a launch-time reference model.
module tb_fifo_reader;

    localparam int DW     = 8;
    localparam int RD_LOW = 4;
    localparam int GAP    = 1;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             nempty;
    logic [DW-1:0]    fifo_data;
    logic             fiford;
    logic [DW-1:0]    dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic [CNT_W-1:0] rd_count;

    int checks = 0;
    int errors = 0;

    fifo_reader #(
        .DW(DW),
        .RD_LOW_CYCLES(RD_LOW),
        .GAP_CYCLES(GAP),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .nempty     (nempty),
        .fifo_data  (fifo_data),
        .fiford     (fiford),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Source FIFO: head word on fifo_data, one word consumed per completed strobe.
    logic [DW-1:0] fq[$];

    task automatic upd_fifo();
        nempty    = (fq.size() != 0);
        fifo_data = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        upd_fifo();
    endtask

    always @(posedge fiford) begin
        if (rst && fq.size() > 0) begin
            void'(fq.pop_front());
            upd_fifo();
        end
    end

    // Reference model: a read launched at edge L strobes for RD_LOW edges, captures at L+RD_LOW,
    // and the engine may launch again from edge L+RD_LOW+GAP+1.
    logic [DW-1:0] mbuf[$];
    int  n = 0;
    int  L = -1000;
    int  mcnt = 0;
    bit  exp_fiford = 1'b1;
    bit  exp_busy = 1'b0;

    always @(posedge clk or negedge rst) begin
        bit pop_now, cap_now, can_launch;
        if (!rst) begin
            mbuf.delete();
            mcnt       = 0;
            L          = -1000;
            exp_fiford = 1'b1;
            exp_busy   = 1'b0;
        end else begin
            n++;
            pop_now    = (mbuf.size() != 0) && dout_ready;
            cap_now    = (n == L + RD_LOW);
            can_launch = (n >= L + RD_LOW + GAP + 1) && en && nempty && (mbuf.size() < 2);
            if (pop_now) void'(mbuf.pop_front());
            if (cap_now) begin
                mbuf.push_back(fifo_data);
                mcnt = (mcnt + 1) % (1 << CNT_W);
            end
            if (can_launch) L = n;
            exp_fiford = !(n >= L && n <= L + RD_LOW - 1);
            exp_busy   = (n >= L && n <= L + RD_LOW + GAP - 1);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("fiford", 32'(fiford), 32'(exp_fiford));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("dout_valid", 32'(dout_valid), 32'(mbuf.size() != 0));
            if (mbuf.size() != 0) chk("dout", 32'(dout), 32'(mbuf[0]));
            chk("rd_count", 32'(rd_count), 32'(mcnt));
        end
    end

    // Stream sink, strobe counter and strobe-width monitor.
    logic [DW-1:0] got[$];
    int strobes = 0;
    int lowcnt = 0;
    int cyc = 0;
    int starts[$];
    bit prev_fr = 1'b1;

    always @(posedge clk) begin
        if (rst && dout_valid && dout_ready) got.push_back(dout);
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            lowcnt = 0;
        end else if (fiford == 1'b0) begin
            if (prev_fr) begin
                strobes++;
                starts.push_back(cyc);
            end
            lowcnt++;
        end else if (lowcnt > 0) begin
            chk("strobe_width", 32'(lowcnt), 32'(RD_LOW));
            lowcnt = 0;
        end
        prev_fr = fiford;
    end

    task automatic wait_got(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (got.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(got.size()), 32'(target));
    endtask

    task automatic wait_low(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (fiford !== 1'b0 && k < 50);
        chk(nm, 32'(fiford), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] w8[8];
        logic [DW-1:0] w5[5];
        logic [DW-1:0] w3[3];
        logic [DW-1:0] rq[$];
        int s0, g0, done;

        w8 = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
        w5 = '{8'h5A, 8'hC3, 8'h17, 8'hE8, 8'h3F};
        w3 = '{8'hA1, 8'hA2, 8'hA3};
        rst = 1'b0;
        en = 1'b1;
        dout_ready = 1'b1;
        upd_fifo();
        repeat (3) @(negedge clk);
        chk("rst_fiford", 32'(fiford), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("empty_fiford", 32'(fiford), 32'd1);
            chk("empty_valid", 32'(dout_valid), 32'd0);
            chk("empty_busy", 32'(busy), 32'd0);
        end

        // Eight-word drain with a always-ready consumer.
        s0 = strobes; g0 = got.size();
        for (int i = 0; i < 8; i++) push(w8[i]);
        wait_got(g0 + 8, 150, "drain8_words");
        for (int i = 0; i < 8 && g0 + i < got.size(); i++) chk("drain8_order", 32'(got[g0 + i]), 32'(w8[i]));
        chk("drain8_rd_count", 32'(rd_count), 32'd8);
        for (int i = 0; i < 7 && s0 + i + 1 < starts.size(); i++)
            chk("drain8_period", 32'(starts[s0 + i + 1] - starts[s0 + i]), 32'd6);
        repeat (20) @(negedge clk);
        chk("drain8_strobes", 32'(strobes - s0), 32'd8);
        done = 8;

        // Back-pressure: only two reads fit before the buffer is full.
        dout_ready = 1'b0;
        s0 = strobes; g0 = got.size();
        for (int i = 0; i < 5; i++) push(w5[i]);
        repeat (40) @(negedge clk);
        chk("bp_strobes", 32'(strobes - s0), 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_dout_stable", 32'(dout), 32'(w5[0]));
            chk("bp_fiford_idle", 32'(fiford), 32'd1);
            @(negedge clk);
        end
        dout_ready = 1'b1;
        wait_got(g0 + 5, 100, "bp_words");
        for (int i = 0; i < 5 && g0 + i < got.size(); i++) chk("bp_order", 32'(got[g0 + i]), 32'(w5[i]));
        done += 5;

        // Enable drop in the second strobe cycle: the read in flight still completes.
        s0 = strobes; g0 = got.size();
        for (int i = 0; i < 3; i++) push(w3[i]);
        wait_low("endrop_launch");
        @(negedge clk);
        en = 1'b0;
        repeat (30) @(negedge clk);
        chk("endrop_strobes", 32'(strobes - s0), 32'd1);
        chk("endrop_words", 32'(got.size()), 32'(g0 + 1));
        chk("endrop_rd_count", 32'(rd_count), 32'((done + 1) % 16));
        en = 1'b1;
        wait_got(g0 + 3, 60, "endrop_resume");
        for (int i = 0; i < 3 && g0 + i < got.size(); i++) chk("endrop_order", 32'(got[g0 + i]), 32'(w3[i]));

        // Reset in the third strobe cycle aborts the read without a capture.
        g0 = got.size();
        for (int i = 0; i < 3; i++) push(w3[i] ^ 8'hFF);
        wait_low("rstmid_launch");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_fiford", 32'(fiford), 32'd1);
        chk("rstmid_valid", 32'(dout_valid), 32'd0);
        chk("rstmid_rd_count", 32'(rd_count), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_nocapture", 32'(got.size()), 32'(g0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_got(g0 + 3, 60, "rstmid_resume");
        for (int i = 0; i < 3 && g0 + i < got.size(); i++) chk("rstmid_order", 32'(got[g0 + i]), 32'(w3[i] ^ 8'hFF));
        chk("rstmid_rd_count_after", 32'(rd_count), 32'd3);

        // Counter wrap with a 4-bit rd_count: 17 captures from reset read back 1.
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        g0 = got.size();
        for (int i = 0; i < 17; i++) push(8'(i * 7 + 3));
        wait_got(g0 + 17, 17 * 6 + 60, "wrap_words");
        chk("wrap_rd_count", 32'(rd_count), 32'd1);

        // Random traffic: enable, pushes and back-pressure all toggled freely.
        g0 = got.size();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            dout_ready = ($urandom_range(0, 2) != 0);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                rq.push_back(8'($urandom));
                push(rq[rq.size() - 1]);
            end
        end
        @(negedge clk);
        en = 1'b1;
        dout_ready = 1'b1;
        wait_got(g0 + rq.size(), 3000, "rand_words");
        for (int i = 0; i < rq.size() && g0 + i < got.size(); i++) chk("rand_order", 32'(got[g0 + i]), 32'(rq[i]));
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
